tictactoe_game: RTL and testbench

Sequential game controller that owns the board state and drives the `x`/`o` occupancy vectors consumed by the board evaluation logic. It accepts one move per handshake, validates it, and enforces turn alternation. It detects win or draw one cycle after each accepted move and keeps saturating score counters across games. It sits between the player-input front end and the board/status display path.

---
 rtl/ttt_pkg.sv | 12 +
 rtl/ttt_line_check.sv | 15 +
 rtl/tictactoe_game.sv | 119 +++++++++++
 tb/tb_tictactoe_game.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: shared types, cell count and win-line masks for the tic-tac-toe controller
package ttt_pkg;
    typedef enum logic [1:0] {WAIT_X, WAIT_O, CHECK, DONE} state_t;
    typedef enum logic [1:0] {NONE = 2'd0, RANGE = 2'd1, TURN = 2'd2, OCC = 2'd3} err_t;
    localparam int NUM_CELLS = 9;
    // rows, columns, then the 0-4-8 and 2-4-6 diagonals; bit n is cell n (row-major)
    localparam logic [7:0][NUM_CELLS-1:0] WIN_LINES = {
        9'h007, 9'h038, 9'h1c0,
        9'h049, 9'h092, 9'h124,
        9'h111, 9'h054
    };
endpackage

// File: rtl/ttt_line_check.sv
// ttt_line_check: flags a completed row, column or diagonal on one player's board
//   board in 9: occupancy of one player, row-major
//   win   out 1: some win line is fully covered
module ttt_line_check
    import ttt_pkg::*;
(
    input  logic [NUM_CELLS-1:0] board,
    output logic                 win
);
    always_comb begin
        win = 1'b0;
        for (int i = 0; i < 8; i++)
            win = win | ((board & WIN_LINES[i]) == WIN_LINES[i]);
    end
endmodule

// File: rtl/tictactoe_game.sv
// tictactoe_game: move validation, turn alternation, win/draw detection and score keeping
//   clk, rst (sync, active high); new_game clears board, keeps scores
//   move_valid/move_ready handshake with move_cell (0..8) and move_player (0 = X, 1 = O)
//   move_ack / move_err + err_code: one-cycle result of every handshake
//   x, o: board occupancy; turn: next mover; game_over/win_x/win_o/draw: outcome
//   score_x, score_o, score_draw: saturating game counts
module tictactoe_game
    import ttt_pkg::*;
#(
    parameter bit FIRST_PLAYER = 1'b0,
    parameter bit ALT_START    = 1'b0,
    parameter int SCORE_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 new_game,
    input  logic                 move_valid,
    output logic                 move_ready,
    input  logic [3:0]           move_cell,
    input  logic                 move_player,
    output logic                 move_ack,
    output logic                 move_err,
    output logic [1:0]           err_code,
    output logic [NUM_CELLS-1:0] x,
    output logic [NUM_CELLS-1:0] o,
    output logic                 turn,
    output logic                 game_over,
    output logic                 win_x,
    output logic                 win_o,
    output logic                 draw,
    output logic [SCORE_W-1:0]   score_x,
    output logic [SCORE_W-1:0]   score_o,
    output logic [SCORE_W-1:0]   score_draw
);
    state_t               state, state_nx;
    err_t                 code;
    logic [3:0]           move_count;
    logic                 start, start_nx, accept, reject, win;
    logic [NUM_CELLS-1:0] cell_bit, mover;

    // start is the player who opened the current game; ALT_START alternates it
    assign start_nx   = ALT_START ? ~start : FIRST_PLAYER;
    assign cell_bit   = NUM_CELLS'(1) << move_cell;
    assign code       = move_cell > 4'd8 ? RANGE :
                        move_player != turn ? TURN :
                        |((x | o) & cell_bit) ? OCC : NONE;
    assign move_ready = (state == WAIT_X || state == WAIT_O) && !new_game;
    assign accept     = move_valid && move_ready && code == NONE;
    assign reject     = move_valid && move_ready && code != NONE;
    assign game_over  = state == DONE;
    // turn still names the mover while in CHECK, so its board is the one evaluated
    assign mover      = turn ? o : x;

    ttt_line_check u_line_check (.board(mover), .win(win));

    always_ff @(posedge clk)
        if (rst) state <= FIRST_PLAYER ? WAIT_O : WAIT_X;
        else     state <= state_nx;

    always_comb begin
        state_nx = state;
        if (new_game)
            state_nx = start_nx ? WAIT_O : WAIT_X;
        else if (accept)
            state_nx = CHECK;
        else if (state == CHECK)
            state_nx = win || move_count == 4'd9 ? DONE : turn ? WAIT_X : WAIT_O;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            o          <= '0;
            turn       <= FIRST_PLAYER;
            start      <= FIRST_PLAYER;
            move_count <= '0;
            move_ack   <= 1'b0;
            move_err   <= 1'b0;
            err_code   <= NONE;
            win_x      <= 1'b0;
            win_o      <= 1'b0;
            draw       <= 1'b0;
            score_x    <= '0;
            score_o    <= '0;
            score_draw <= '0;
        end else begin
            move_ack <= accept;
            move_err <= reject;
            err_code <= reject ? code : NONE;
            if (new_game) begin
                x          <= '0;
                o          <= '0;
                move_count <= '0;
                win_x      <= 1'b0;
                win_o      <= 1'b0;
                draw       <= 1'b0;
                turn       <= start_nx;
                start      <= start_nx;
            end else if (accept) begin
                if (turn) o <= o | cell_bit;
                else      x <= x | cell_bit;
                move_count <= move_count + 4'd1;
            end else if (state == CHECK) begin
                if (win && turn) begin
                    win_o   <= 1'b1;
                    score_o <= score_o + SCORE_W'(score_o != '1);
                end else if (win) begin
                    win_x   <= 1'b1;
                    score_x <= score_x + SCORE_W'(score_x != '1);
                end else if (move_count == 4'd9) begin
                    draw       <= 1'b1;
                    score_draw <= score_draw + SCORE_W'(score_draw != '1);
                end else begin
                    turn <= ~turn;
                end
            end
        end
    end
endmodule

// File: tb/tb_tictactoe_game.sv
// tb_tictactoe_game: scoreboard bench driving a default and an alternating-start, 2-bit-score controller
module tb_tictactoe_game;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] ng = '0, mv = '0, mp = '0;
    logic [1:0][3:0] mc = '0;
    logic [1:0] rdy, ack, err, trn, ovr, wxo, woo, dro;
    logic [1:0][1:0] ec;
    logic [1:0][8:0] xb, ob;
    logic [7:0] sx0, so0, sd0;
    logic [1:0] sx1, so1, sd1;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    tictactoe_game u0 (
        .clk(clk), .rst(rst), .new_game(ng[0]), .move_valid(mv[0]), .move_ready(rdy[0]),
        .move_cell(mc[0]), .move_player(mp[0]), .move_ack(ack[0]), .move_err(err[0]),
        .err_code(ec[0]), .x(xb[0]), .o(ob[0]), .turn(trn[0]), .game_over(ovr[0]),
        .win_x(wxo[0]), .win_o(woo[0]), .draw(dro[0]),
        .score_x(sx0), .score_o(so0), .score_draw(sd0)
    );

    tictactoe_game #(.FIRST_PLAYER(1'b1), .ALT_START(1'b1), .SCORE_W(2)) u1 (
        .clk(clk), .rst(rst), .new_game(ng[1]), .move_valid(mv[1]), .move_ready(rdy[1]),
        .move_cell(mc[1]), .move_player(mp[1]), .move_ack(ack[1]), .move_err(err[1]),
        .err_code(ec[1]), .x(xb[1]), .o(ob[1]), .turn(trn[1]), .game_over(ovr[1]),
        .win_x(wxo[1]), .win_o(woo[1]), .draw(dro[1]),
        .score_x(sx1), .score_o(so1), .score_draw(sd1)
    );

    typedef struct { bit ack; bit err; int code; int xv; int ov; bit turn; } resp_t;
    typedef struct { bit wx; bit wo; bit dr; bit over; bit turn; int sx; int so; int sd; int xv; int ov; } eval_t;
    resp_t rq[2][$];
    eval_t eq[2][$];

    // game-level reference: cells hold 0 empty, 1 X, 2 O
    int cells[2][9];
    bit m_turn[2], m_start[2], m_pend[2], m_done[2], m_wx[2], m_wo[2], m_dr[2];
    int m_cnt[2], m_sx[2], m_so[2], m_sd[2];
    int xl[$], ol[$];

    function automatic bit fp(int i);   return i == 1; endfunction
    function automatic bit alt(int i);  return i == 1; endfunction
    function automatic int smax(int i); return i == 1 ? 3 : 255; endfunction
    function automatic int scx(int i);  return i == 1 ? int'(sx1) : int'(sx0); endfunction
    function automatic int sco(int i);  return i == 1 ? int'(so1) : int'(so0); endfunction
    function automatic int scd(int i);  return i == 1 ? int'(sd1) : int'(sd0); endfunction

    function automatic int board(int i, int p);
        int b = 0;
        for (int k = 0; k < 9; k++) if (cells[i][k] == p) b += 1 << k;
        return b;
    endfunction

    function automatic bit won(int i, int p);
        bit w = 1'b0;
        for (int r = 0; r < 3; r++) begin
            w |= cells[i][3*r] == p && cells[i][3*r+1] == p && cells[i][3*r+2] == p;
            w |= cells[i][r] == p && cells[i][r+3] == p && cells[i][r+6] == p;
        end
        w |= cells[i][0] == p && cells[i][4] == p && cells[i][8] == p;
        w |= cells[i][2] == p && cells[i][4] == p && cells[i][6] == p;
        return w;
    endfunction

    function automatic eval_t snap(int i);
        eval_t e;
        e.wx = m_wx[i]; e.wo = m_wo[i]; e.dr = m_dr[i]; e.over = m_done[i]; e.turn = m_turn[i];
        e.sx = m_sx[i]; e.so = m_so[i]; e.sd = m_sd[i];
        e.xv = board(i, 1); e.ov = board(i, 2);
        return e;
    endfunction

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_game(int i);
        for (int k = 0; k < 9; k++) cells[i][k] = 0;
        m_cnt[i] = 0; m_wx[i] = 0; m_wo[i] = 0; m_dr[i] = 0; m_done[i] = 0; m_pend[i] = 0;
    endtask

    task automatic model_reset(int i);
        clear_game(i);
        m_turn[i] = fp(i); m_start[i] = fp(i);
        m_sx[i] = 0; m_so[i] = 0; m_sd[i] = 0;
        rq[i].delete(); eq[i].delete();
    endtask

    // advance the model across the coming clock edge using the inputs now driven
    task automatic model_step(int i);
        if (ng[i]) begin
            bit was = m_pend[i];
            m_start[i] = alt(i) ? !m_start[i] : fp(i);
            clear_game(i);
            m_turn[i] = m_start[i];
            if (was) eq[i].push_back(snap(i));
        end else if (m_pend[i]) begin
            int p = m_turn[i] ? 2 : 1;
            m_pend[i] = 0;
            if (won(i, p)) begin
                m_done[i] = 1;
                if (p == 1) begin m_wx[i] = 1; if (m_sx[i] < smax(i)) m_sx[i]++; end
                else        begin m_wo[i] = 1; if (m_so[i] < smax(i)) m_so[i]++; end
            end else if (m_cnt[i] == 9) begin
                m_done[i] = 1; m_dr[i] = 1;
                if (m_sd[i] < smax(i)) m_sd[i]++;
            end else begin
                m_turn[i] = !m_turn[i];
            end
            eq[i].push_back(snap(i));
        end else if (mv[i] && !m_done[i]) begin
            int c = int'(mc[i]);
            int code = c > 8 ? 1 : mp[i] != m_turn[i] ? 2 : cells[i][c] != 0 ? 3 : 0;
            resp_t r;
            if (code == 0) begin
                cells[i][c] = m_turn[i] ? 2 : 1;
                m_cnt[i]++;
                m_pend[i] = 1;
            end
            r = '{code == 0, code != 0, code, board(i, 1), board(i, 2), m_turn[i]};
            rq[i].push_back(r);
        end
    endtask

    task automatic cycle();
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("u%0d_move_ready", i), rdy[i], !m_pend[i] && !m_done[i] && !ng[i]);
        for (int i = 0; i < 2; i++) model_step(i);
        @(posedge clk);
        #1;
    endtask

    task automatic move(int i, int c, bit p);
        mv[i] = 1'b1; mc[i] = 4'(c); mp[i] = p;
        cycle();
        mv[i] = 1'b0;
        cycle();
    endtask

    task automatic newgame(int i);
        ng[i] = 1'b1;
        cycle();
        ng[i] = 1'b0;
    endtask

    task automatic play(int i);
        while (!m_done[i] && (m_turn[i] ? ol.size() : xl.size()) > 0) begin
            bit p = m_turn[i];
            int c = p ? ol.pop_front() : xl.pop_front();
            move(i, c, p);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ng = '0; mv = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            check($sformatf("u%0d_rst_x", i), xb[i], 0);
            check($sformatf("u%0d_rst_o", i), ob[i], 0);
            check($sformatf("u%0d_rst_turn", i), trn[i], fp(i));
            check($sformatf("u%0d_rst_ack_err", i), {ack[i], err[i], ec[i]}, 0);
            check($sformatf("u%0d_rst_flags", i), {ovr[i], wxo[i], woo[i], dro[i]}, 0);
            check($sformatf("u%0d_rst_scores", i), scx(i) + sco(i) + scd(i), 0);
        end
        rst = 1'b0;
    endtask

    // monitor: pops a move result on every ack/err, and the evaluation the cycle after an ack
    initial begin
        bit saw[2];
        resp_t r;
        eval_t e;
        saw = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    saw[i] = 1'b0;
                end else begin
                    if (ack[i] || err[i]) begin
                        if (rq[i].size() == 0) begin
                            check($sformatf("u%0d_unexpected_resp", i), {ack[i], err[i]}, 0);
                        end else begin
                            r = rq[i].pop_front();
                            check($sformatf("u%0d_ack", i), ack[i], r.ack);
                            check($sformatf("u%0d_err", i), err[i], r.err);
                            check($sformatf("u%0d_err_code", i), ec[i], r.code);
                            check($sformatf("u%0d_resp_x", i), xb[i], r.xv);
                            check($sformatf("u%0d_resp_o", i), ob[i], r.ov);
                            check($sformatf("u%0d_resp_turn", i), trn[i], r.turn);
                        end
                    end
                    if (saw[i]) begin
                        if (eq[i].size() == 0) begin
                            check($sformatf("u%0d_missing_eval", i), eq[i].size(), 1);
                        end else begin
                            e = eq[i].pop_front();
                            check($sformatf("u%0d_win_x", i), wxo[i], e.wx);
                            check($sformatf("u%0d_win_o", i), woo[i], e.wo);
                            check($sformatf("u%0d_draw", i), dro[i], e.dr);
                            check($sformatf("u%0d_game_over", i), ovr[i], e.over);
                            check($sformatf("u%0d_turn", i), trn[i], e.turn);
                            check($sformatf("u%0d_score_x", i), scx(i), e.sx);
                            check($sformatf("u%0d_score_o", i), sco(i), e.so);
                            check($sformatf("u%0d_score_draw", i), scd(i), e.sd);
                            check($sformatf("u%0d_eval_x", i), xb[i], e.xv);
                            check($sformatf("u%0d_eval_o", i), ob[i], e.ov);
                        end
                    end
                    saw[i] = ack[i];
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        xl = '{0, 1, 2}; ol = '{3, 4};
        play(0);
        check("x_row_win_flag", wxo[0], 1);
        check("x_row_win_score", sx0, 1);
        check("x_row_win_over", ovr[0], 1);

        newgame(0);
        move(0, 4, 1'b0);
        move(0, 4, 1'b1);
        check("occupied_o_unchanged", ob[0], 0);
        check("occupied_turn_stays_o", trn[0], 1);
        move(0, 9, 1'b0);

        newgame(0);
        xl = '{0, 2, 3, 7, 8}; ol = '{1, 4, 5, 6};
        play(0);
        check("draw_x_board", xb[0], 9'h18d);
        check("draw_o_board", ob[0], 9'h072);
        check("draw_flag", dro[0], 1);
        check("draw_score", sd0, 1);

        move(1, 4, 1'b1);
        ng[1] = 1'b1; mv[1] = 1'b1; mc[1] = 4'd5; mp[1] = m_turn[1];
        cycle();
        ng[1] = 1'b0; mv[1] = 1'b0;
        cycle();
        check("alt_newgame_x_clear", xb[1], 0);
        check("alt_newgame_o_clear", ob[1], 0);
        check("alt_newgame_turn", trn[1], 0);

        for (int g = 0; g < 4; g++) begin
            newgame(1);
            xl = '{0, 1, 2}; ol = '{3, 4, 8};
            play(1);
            check($sformatf("sat_game%0d_win_x", g), wxo[1], 1);
        end
        check("score_x_saturated", sx1, 3);

        repeat (600) begin
            for (int i = 0; i < 2; i++) begin
                ng[i] = $urandom_range(0, 15) == 0;
                mv[i] = 1'($urandom_range(0, 1));
                mc[i] = 4'($urandom_range(0, 10));
                mp[i] = $urandom_range(0, 4) == 0 ? !m_turn[i] : m_turn[i];
            end
            cycle();
        end
        ng = '0; mv = '0;
        repeat (3) cycle();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("u%0d_resp_queue_drained", i), rq[i].size(), 0);
            check($sformatf("u%0d_eval_queue_drained", i), eq[i].size(), 0);
        end

        do_reset();
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
